// File: rtl/mips_ctrl_pkg.sv
// Shared control definitions for the multicycle MIPS controller and aludec:
// FSM states, opcodes, aluop codes, mux encodings and the control vector.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_RTYPEEX,
        S_RTYPEWB,
        S_BEQEX,
        S_BLEZEX,
        S_IMMEX,
        S_IMMWB,
        S_JEX
    } mc_state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BLEZ  = 6'b000110;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [3:0] ALUOP_ADD   = 4'b0000;
    localparam logic [3:0] ALUOP_SUB   = 4'b0001;
    localparam logic [3:0] ALUOP_BLEZ  = 4'b0010;
    localparam logic [3:0] ALUOP_OR    = 4'b0011;
    localparam logic [3:0] ALUOP_LUI   = 4'b0100;
    localparam logic [3:0] ALUOP_XOR   = 4'b0101;
    localparam logic [3:0] ALUOP_SLTI  = 4'b0110;
    localparam logic [3:0] ALUOP_ANDI  = 4'b0111;
    localparam logic [3:0] ALUOP_RTYPE = 4'b1000;

    localparam logic [1:0] ALUSRCB_B      = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
    localparam logic [1:0] ALUSRCB_BRANCH = 2'b11;

    localparam logic [1:0] PCSRC_ALURESULT = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT    = 2'b01;
    localparam logic [1:0] PCSRC_JUMP      = 2'b10;

    typedef struct packed {
        logic       irwrite;
        logic       pcwrite;
        logic       branch;
        logic       memwrite;
        logic       regwrite;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       zeroext;
        logic [3:0] aluop;
    } mc_ctrl_t;

    // Immediate-class ALU operation; anything that is not an immediate op maps to add.
    function automatic logic [3:0] imm_aluop(input logic [5:0] op);
        case (op)
            OP_ORI:  return ALUOP_OR;
            OP_LUI:  return ALUOP_LUI;
            OP_XORI: return ALUOP_XOR;
            OP_SLTI: return ALUOP_SLTI;
            OP_ANDI: return ALUOP_ANDI;
            default: return ALUOP_ADD;
        endcase
    endfunction

    function automatic logic imm_zeroext(input logic [5:0] op);
        return (op == OP_ORI) || (op == OP_XORI) || (op == OP_ANDI);
    endfunction

endpackage

// File: rtl/mc_ctrl_rom.sv
// Combinational control store: maps the FSM state (plus the immediate-op
// registers captured in DECODE) to the datapath control vector.
module mc_ctrl_rom
    import mips_ctrl_pkg::*;
(
    input  mc_state_t  state,
    input  logic [3:0] imm_aluop_q,
    input  logic       zeroext_q,
    output mc_ctrl_t   ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.irwrite = 1'b1;
                ctrl.pcwrite = 1'b1;
                ctrl.alusrcb = ALUSRCB_FOUR;
                ctrl.aluop   = ALUOP_ADD;
            end
            // Branch target is computed speculatively while the opcode decodes.
            S_DECODE: begin
                ctrl.alusrcb = ALUSRCB_BRANCH;
                ctrl.aluop   = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = ALUSRCB_IMM;
                ctrl.aluop   = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.iord = 1'b1;
            end
            S_MEMWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord     = 1'b1;
                ctrl.memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = ALUSRCB_B;
                ctrl.aluop   = ALUOP_RTYPE;
            end
            S_RTYPEWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = 1'b1;
            end
            S_BEQEX, S_BLEZEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = ALUSRCB_B;
                ctrl.aluop   = (state == S_BLEZEX) ? ALUOP_BLEZ : ALUOP_SUB;
                ctrl.pcsrc   = PCSRC_ALUOUT;
                ctrl.branch  = 1'b1;
            end
            S_IMMEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = ALUSRCB_IMM;
                ctrl.aluop   = imm_aluop_q;
                ctrl.zeroext = zeroext_q;
            end
            S_IMMWB: begin
                ctrl.regwrite = 1'b1;
            end
            S_JEX: begin
                ctrl.pcwrite = 1'b1;
                ctrl.pcsrc   = PCSRC_JUMP;
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/mc_maindec.sv
// Multicycle main control FSM: state register, next-state logic and the
// immediate-op registers captured in DECODE; outputs come from mc_ctrl_rom.
module mc_maindec
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       branch,
    output logic       memwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       zeroext,
    output logic [3:0] aluop,
    output logic       illegal
);

    mc_state_t  state_q, state_d;
    logic [3:0] imm_aluop_q, imm_aluop_d;
    logic       zeroext_q, zeroext_d;
    mc_ctrl_t   ctrl;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_FETCH;
            imm_aluop_q <= ALUOP_ADD;
            zeroext_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            imm_aluop_q <= imm_aluop_d;
            zeroext_q   <= zeroext_d;
        end
    end

    always_comb begin
        state_d     = S_FETCH;
        imm_aluop_d = imm_aluop_q;
        zeroext_d   = zeroext_q;
        illegal     = 1'b0;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                imm_aluop_d = imm_aluop(op);
                zeroext_d   = imm_zeroext(op);
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_BLEZ:      state_d = S_BLEZEX;
                    OP_ADDI, OP_ORI, OP_LUI,
                    OP_XORI, OP_SLTI, OP_ANDI: state_d = S_IMMEX;
                    OP_J:         state_d = S_JEX;
                    default: begin
                        state_d = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            // Only sw diverts to the write path; lw is the fall-through.
            S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = S_MEMWB;
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_IMMEX:   state_d = S_IMMWB;
            default:   state_d = S_FETCH;
        endcase
    end

    mc_ctrl_rom u_rom (
        .state       (state_q),
        .imm_aluop_q (imm_aluop_q),
        .zeroext_q   (zeroext_q),
        .ctrl        (ctrl)
    );

    assign irwrite  = ctrl.irwrite;
    assign pcwrite  = ctrl.pcwrite;
    assign branch   = ctrl.branch;
    assign memwrite = ctrl.memwrite;
    assign regwrite = ctrl.regwrite;
    assign iord     = ctrl.iord;
    assign memtoreg = ctrl.memtoreg;
    assign regdst   = ctrl.regdst;
    assign alusrca  = ctrl.alusrca;
    assign alusrcb  = ctrl.alusrcb;
    assign pcsrc    = ctrl.pcsrc;
    assign zeroext  = ctrl.zeroext;
    assign aluop    = ctrl.aluop;

endmodule

// File: tb/tb_mc_maindec.sv
// Bench for mc_maindec: per-instruction cycle tables form the expected queue,
// with random opcode noise driven in every cycle where op must be ignored.
module tb_mc_maindec;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'b0;
    logic       irwrite, pcwrite, branch, memwrite, regwrite, iord;
    logic       memtoreg, regdst, alusrca, zeroext, illegal;
    logic [1:0] alusrcb, pcsrc;
    logic [3:0] aluop;

    int n_checks = 0;
    int n_pass   = 0;
    logic [18:0] exp_q[$];
    logic [5:0] legal_ops[12] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                                  6'b000110, 6'b001000, 6'b001101, 6'b001111,
                                  6'b001110, 6'b001010, 6'b001100, 6'b000010};

    // ---------------- clock / DUT ----------------
    always #5 clk = ~clk;

    mc_maindec dut (
        .clk(clk), .reset(reset), .op(op),
        .irwrite(irwrite), .pcwrite(pcwrite), .branch(branch),
        .memwrite(memwrite), .regwrite(regwrite), .iord(iord),
        .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .zeroext(zeroext),
        .aluop(aluop), .illegal(illegal)
    );

    wire [18:0] obs = {irwrite, pcwrite, branch, memwrite, regwrite, iord, memtoreg,
                       regdst, alusrca, alusrcb, pcsrc, zeroext, aluop, illegal};

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [18:0] v(input logic irw, input logic pcw, input logic br,
                                      input logic mw, input logic rw, input logic io,
                                      input logic m2r, input logic rd, input logic asa,
                                      input logic [1:0] asb, input logic [1:0] pcs,
                                      input logic zx, input logic [3:0] aop, input logic ill);
        return {irw, pcw, br, mw, rw, io, m2r, rd, asa, asb, pcs, zx, aop, ill};
    endfunction

    function automatic logic [18:0] fetch_vec();
        return v(1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 4'h0, 0);
    endfunction

    function automatic bit is_legal(input logic [5:0] o);
        foreach (legal_ops[i]) if (legal_ops[i] == o) return 1'b1;
        return 1'b0;
    endfunction

    // Expected cycle-by-cycle outputs of one instruction, FETCH included.
    task automatic push_instr(input logic [5:0] o);
        exp_q.push_back(fetch_vec());
        exp_q.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 4'h0, !is_legal(o)));
        case (o)
            6'b100011: begin
                exp_q.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 4'h0, 0));
                exp_q.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 4'h0, 0));
                exp_q.push_back(v(0, 0, 0, 0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 0, 4'h0, 0));
            end
            6'b101011: begin
                exp_q.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 4'h0, 0));
                exp_q.push_back(v(0, 0, 0, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 4'h0, 0));
            end
            6'b000000: begin
                exp_q.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 4'h8, 0));
                exp_q.push_back(v(0, 0, 0, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0, 4'h0, 0));
            end
            6'b000100: exp_q.push_back(v(0, 0, 1, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 0, 4'h1, 0));
            6'b000110: exp_q.push_back(v(0, 0, 1, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 0, 4'h2, 0));
            6'b000010: exp_q.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 0, 4'h0, 0));
            6'b001000, 6'b001101, 6'b001111, 6'b001110, 6'b001010, 6'b001100: begin
                logic [3:0] code;
                logic       zx;
                code = (o == 6'b001101) ? 4'h3 : (o == 6'b001111) ? 4'h4 :
                       (o == 6'b001110) ? 4'h5 : (o == 6'b001010) ? 4'h6 :
                       (o == 6'b001100) ? 4'h7 : 4'h0;
                zx = (o == 6'b001101) || (o == 6'b001110) || (o == 6'b001100);
                exp_q.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, zx, code, 0));
                exp_q.push_back(v(0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 4'h0, 0));
            end
            default: ;
        endcase
    endtask

    // ---------------- driver ----------------
    // Entered and left at posedge+1 with the DUT in FETCH. op is held at the
    // instruction's opcode only in DECODE (and MEMADR for loads/stores).
    task automatic run_instr(input logic [5:0] o, input bit fixed_noise, input logic [5:0] noise,
                             input int stop_after);
        int n;
        bit mem;
        push_instr(o);
        n = exp_q.size();
        mem = (o == 6'b100011) || (o == 6'b101011);
        for (int c = 0; c < n; c++) begin
            if (c == 1 || (c == 2 && mem)) op = o;
            else op = fixed_noise ? noise : 6'($urandom_range(0, 63));
            #1;
            chk($sformatf("op%b cyc%0d", o, c + 1), 32'(obs), 32'(exp_q.pop_front()));
            if (c + 1 == stop_after) begin
                exp_q.delete();
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [5:0] pick_op();
        int idx;
        idx = $urandom_range(0, 14);
        if (idx < 12) return legal_ops[idx];
        return 6'($urandom_range(0, 63));
    endfunction

    // ---------------- main ----------------
    initial begin
        reset = 1'b1;
        op = 6'($urandom_range(0, 63));
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 32'(obs), 32'(fetch_vec()));
        reset = 1'b0;

        // Directed: one of each opcode class; ori sees addi during IMMEX.
        run_instr(6'b100011, 0, 6'b0, 0);
        run_instr(6'b000000, 0, 6'b0, 0);
        run_instr(6'b001101, 1, 6'b001000, 0);
        run_instr(6'b000110, 0, 6'b0, 0);
        run_instr(6'b111111, 0, 6'b0, 0);
        foreach (legal_ops[i]) run_instr(legal_ops[i], 0, 6'b0, 0);

        // Reset held for two cycles while lw sits in MEMRD.
        run_instr(6'b100011, 0, 6'b0, 4);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_hold", 32'(obs), 32'(fetch_vec()));
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("post_reset_iord", 32'(iord), 32'(0));
        run_instr(6'b101011, 0, 6'b0, 0);

        for (int k = 0; k < 200; k++) run_instr(pick_op(), 0, 6'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
